// File: rtl/axi4_lite_master_if.sv
// Command/response port plus the five AXI4-Lite channels of axi4_lite_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface axi4_lite_master_if #(
  parameter int addr_width = 3,
  parameter int data_width = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [addr_width-1:0]     cmd_addr;
  logic [data_width-1:0]     cmd_wdata;
  logic [data_width/8-1:0]   cmd_wstrb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [data_width-1:0]     rsp_rdata;
  logic [1:0]                rsp_resp;
  logic                      awvalid;
  logic                      awready;
  logic [addr_width-1:0]     awaddr;
  logic                      awprot;
  logic                      wvalid;
  logic                      wready;
  logic [data_width-1:0]     wdata;
  logic [data_width/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [addr_width-1:0]     araddr;
  logic                      arprot;
  logic                      rvalid;
  logic                      rready;
  logic [data_width-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: one command becomes an AW/W/B or AR/R
// exchange; the B/R wait is bounded by a timeout that reports 2'b10.
module axi4_lite_master #(
  parameter int addr_width     = 3,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 16
) (
  input logic                aclk,
  input logic                areset,
  axi4_lite_master_if.master bus
);
  localparam int STRB_W = data_width / 8;
  localparam int CNT_W  = $clog2(timeout_cycles + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(timeout_cycles - 1);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_aw_done, w_aw_done_next;
  logic                  r_w_done, w_w_done_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [addr_width-1:0] r_addr, w_addr_next;
  logic [data_width-1:0] r_wdata, w_wdata_next;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_next;
  logic [data_width-1:0] r_rsp_rdata, w_rsp_rdata_next;
  logic [1:0]            r_rsp_resp, w_rsp_resp_next;
  logic                  r_cmd_ready, w_cmd_ready_next;
  logic                  r_awvalid, w_awvalid_next;
  logic                  r_wvalid, w_wvalid_next;
  logic                  r_bready, w_bready_next;
  logic                  r_arvalid, w_arvalid_next;
  logic                  r_rready, w_rready_next;
  logic                  r_rsp_valid, w_rsp_valid_next;

  always_comb begin
    w_state_next     = r_state;
    w_aw_done_next   = r_aw_done;
    w_w_done_next    = r_w_done;
    w_cnt_next       = r_cnt;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_wstrb_next     = r_wstrb;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_resp_next  = r_rsp_resp;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_addr_next    = bus.cmd_addr;
          w_wdata_next   = bus.cmd_wdata;
          w_wstrb_next   = bus.cmd_wstrb;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
          w_state_next   = bus.cmd_write ? S_WR_REQ : S_RD_REQ;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WR_REQ: begin
        w_aw_done_next = r_aw_done | (r_awvalid & bus.awready);
        w_w_done_next  = r_w_done | (r_wvalid & bus.wready);
        if (w_aw_done_next && w_w_done_next) begin
          w_cnt_next   = '0;
          w_state_next = S_WR_RESP;
        end else begin
          w_state_next = S_WR_REQ;
        end
      end
      S_WR_RESP: begin
        if (bus.bvalid && r_bready) begin
          w_rsp_resp_next  = bus.bresp;
          w_rsp_rdata_next = '0;
          w_state_next     = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_resp_next  = RESP_SLVERR;
          w_rsp_rdata_next = '0;
          w_state_next     = S_DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_RD_REQ: begin
        if (r_arvalid && bus.arready) begin
          w_cnt_next   = '0;
          w_state_next = S_RD_RESP;
        end else begin
          w_state_next = S_RD_REQ;
        end
      end
      S_RD_RESP: begin
        if (bus.rvalid && r_rready) begin
          w_rsp_resp_next  = bus.rresp;
          w_rsp_rdata_next = bus.rdata;
          w_state_next     = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_resp_next  = RESP_SLVERR;
          w_rsp_rdata_next = '0;
          w_state_next     = S_DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.rsp_ready && r_rsp_valid) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered.
    w_cmd_ready_next = (w_state_next == S_IDLE);
    w_awvalid_next   = (w_state_next == S_WR_REQ) && !w_aw_done_next;
    w_wvalid_next    = (w_state_next == S_WR_REQ) && !w_w_done_next;
    w_bready_next    = (w_state_next == S_WR_RESP);
    w_arvalid_next   = (w_state_next == S_RD_REQ);
    w_rready_next    = (w_state_next == S_RD_RESP);
    w_rsp_valid_next = (w_state_next == S_DONE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_aw_done   <= w_aw_done_next;
      r_w_done    <= w_w_done_next;
      r_cnt       <= w_cnt_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_wstrb     <= w_wstrb_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_resp  <= w_rsp_resp_next;
      r_cmd_ready <= w_cmd_ready_next;
      r_awvalid   <= w_awvalid_next;
      r_wvalid    <= w_wvalid_next;
      r_bready    <= w_bready_next;
      r_arvalid   <= w_arvalid_next;
      r_rready    <= w_rready_next;
      r_rsp_valid <= w_rsp_valid_next;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_resp  = r_rsp_resp;
  assign bus.awvalid   = r_awvalid;
  assign bus.awaddr    = r_addr;
  assign bus.awprot    = 1'b0;
  assign bus.wvalid    = r_wvalid;
  assign bus.wdata     = r_wdata;
  assign bus.wstrb     = r_wstrb;
  assign bus.bready    = r_bready;
  assign bus.arvalid   = r_arvalid;
  assign bus.araddr    = r_addr;
  assign bus.arprot    = 1'b0;
  assign bus.rready    = r_rready;
endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: each transaction is planned as a set of slave delays,
// from which the cycle windows of every output are predicted arithmetically.
module tb_axi4_lite_master;
  localparam int AW  = 3;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_lite_master_if #(.addr_width(AW), .data_width(DW)) bus ();

  axi4_lite_master #(.addr_width(AW), .data_width(DW), .timeout_cycles(TMO)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Current transaction plan: accept cycle, slave delays and derived windows.
  bit          tx_wr = 1'b0;
  bit          tmo = 1'b0;
  int          t0 = 0, da = 0, dw = 0, db = 0, dr = 0, tr = 0, tdone = 0, trel = 0;
  logic [AW-1:0] tx_addr = '0;
  logic [DW-1:0] tx_wdata = '0, tx_rdata = '0, e_rdata = '0;
  logic [3:0]    tx_wstrb = '0;
  logic [1:0]    tx_resp = '0, e_resp = '0;
  bit          chk_en = 1'b0;

  int          obs_aw, obs_w, obs_rsp, obs_rise;
  logic [DW-1:0] obs_rdata;
  logic [1:0]    obs_resp;
  bit          e_aw, e_w, e_b, e_ar, e_r, e_rsp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit rdy_at(input int c, input int st, input int d);
    if (c == st + d) return 1'b1;
    if (c >= st && c < st + d) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Every cycle: outputs must sit inside exactly the windows the plan predicts.
  always @(negedge aclk) begin
    if (chk_en) begin
      e_aw  = tx_wr && cyc > t0 && cyc <= t0 + 1 + da;
      e_w   = tx_wr && cyc > t0 && cyc <= t0 + 1 + dw;
      e_ar  = !tx_wr && cyc > t0 && cyc <= t0 + 1 + da;
      e_b   = tx_wr && cyc >= tr && cyc < tdone;
      e_r   = !tx_wr && cyc >= tr && cyc < tdone;
      e_rsp = cyc >= tdone && cyc <= trel;
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(cyc <= t0));
      chk("awvalid", 64'(bus.awvalid), 64'(e_aw));
      chk("wvalid", 64'(bus.wvalid), 64'(e_w));
      chk("bready", 64'(bus.bready), 64'(e_b));
      chk("arvalid", 64'(bus.arvalid), 64'(e_ar));
      chk("rready", 64'(bus.rready), 64'(e_r));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp));
      chk("prot", 64'({bus.awprot, bus.arprot}), 64'(2'b00));
      if (e_aw) chk("awaddr", 64'(bus.awaddr), 64'(tx_addr));
      if (e_ar) chk("araddr", 64'(bus.araddr), 64'(tx_addr));
      if (e_w) begin
        chk("wdata", 64'(bus.wdata), 64'(tx_wdata));
        chk("wstrb", 64'(bus.wstrb), 64'(tx_wstrb));
      end
      if (e_rsp) begin
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
        chk("rsp_resp", 64'(bus.rsp_resp), 64'(e_resp));
      end
      if (bus.awvalid) obs_aw++;
      if (bus.wvalid) obs_w++;
      if (bus.rsp_valid) begin
        if (obs_rsp == 0) begin
          obs_rise  = cyc;
          obs_rdata = bus.rsp_rdata;
          obs_resp  = bus.rsp_resp;
        end
        obs_rsp++;
      end
    end
  end

  task automatic drive_cycle();
    int c = cyc;
    bit hs;
    bus.cmd_valid = (c == t0);
    bus.cmd_write = (c == t0) ? tx_wr : 1'($urandom);
    bus.cmd_addr  = (c == t0) ? tx_addr : AW'($urandom);
    bus.cmd_wdata = (c == t0) ? tx_wdata : DW'($urandom);
    bus.cmd_wstrb = (c == t0) ? tx_wstrb : 4'($urandom);
    if (tx_wr) begin
      bus.awready = rdy_at(c, t0 + 1, da);
      bus.wready  = rdy_at(c, t0 + 1, dw);
      bus.arready = 1'($urandom);
    end else begin
      bus.awready = 1'($urandom);
      bus.wready  = 1'($urandom);
      bus.arready = rdy_at(c, t0 + 1, da);
    end
    hs = (c == tr + db) && (c < tdone);
    if (tx_wr && c >= tr && c < tdone) begin
      bus.bvalid = hs;
      bus.bresp  = hs ? tx_resp : 2'($urandom);
    end else begin
      bus.bvalid = 1'($urandom);
      bus.bresp  = 2'($urandom);
    end
    if (!tx_wr && c >= tr && c < tdone) begin
      bus.rvalid = hs;
      bus.rdata  = hs ? tx_rdata : DW'($urandom);
      bus.rresp  = hs ? tx_resp : 2'($urandom);
    end else begin
      bus.rvalid = 1'($urandom);
      bus.rdata  = DW'($urandom);
      bus.rresp  = 2'($urandom);
    end
    if (c >= tdone && c < trel) bus.rsp_ready = 1'b0;
    else if (c == trel)         bus.rsp_ready = 1'b1;
    else                        bus.rsp_ready = 1'($urandom);
  endtask

  // Plans one transaction and drives it; returns one cycle after the response is taken.
  task automatic run_txn(input bit wr, input int a_d, input int w_d, input int r_d,
                         input int q_d, input int gap, input int abort_off,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [3:0] ws, input logic [1:0] rs,
                         input logic [DW-1:0] rd);
    tx_wr = wr; da = a_d; dw = wr ? w_d : 0; db = r_d; dr = q_d;
    tx_addr = addr; tx_wdata = wd; tx_wstrb = ws; tx_resp = rs; tx_rdata = rd;
    t0 = cyc + gap;
    tr = wr ? t0 + 2 + ((da > dw) ? da : dw) : t0 + 2 + da;
    tmo = (db >= TMO);
    tdone = tmo ? tr + TMO : tr + db + 1;
    trel = tdone + dr;
    e_resp = tmo ? 2'b10 : rs;
    e_rdata = (wr || tmo) ? '0 : rd;
    obs_aw = 0; obs_w = 0; obs_rsp = 0; obs_rise = -1;
    obs_rdata = '0; obs_resp = '0;
    chk_en = 1'b1;
    while (cyc <= trel && !(abort_off >= 0 && cyc == t0 + abort_off)) begin
      drive_cycle();
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic quiet_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.cmd_ready, bus.rsp_valid, bus.awvalid, bus.wvalid,
                            bus.bready, bus.arvalid, bus.rready}), 64'(7'd0));
    chk({tag, "_addr"}, 64'({bus.awaddr, bus.araddr, bus.awprot, bus.arprot}), 64'(0));
    chk({tag, "_wdata"}, 64'({bus.wdata, bus.wstrb}), 64'(0));
    chk({tag, "_rsp"}, 64'({bus.rsp_rdata, bus.rsp_resp}), 64'(0));
  endtask

  initial begin
    quiet_inputs();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_all_zero("reset");
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_first_cycle", 64'(bus.cmd_ready), 64'(0));
    @(posedge aclk); #1;

    // Zero-wait write: response three cycles after the accept cycle.
    run_txn(1'b1, 0, 0, 0, 0, 0, -1, 3'd3, 32'hA5A5_0F0F, 4'hF, 2'b00, 32'h0);
    chk("wr_min_latency", 64'(obs_rise - t0), 64'(3));
    chk("wr_min_resp", 64'(obs_resp), 64'(2'b00));
    chk("wr_min_aw_cycles", 64'(obs_aw), 64'(1));

    // Write data ready four cycles after address ready.
    run_txn(1'b1, 0, 4, 2, 0, 1, -1, 3'd6, 32'hDEAD_BEEF, 4'h5, 2'b01, 32'h0);
    chk("wr_late_w_aw_cycles", 64'(obs_aw), 64'(1));
    chk("wr_late_w_w_cycles", 64'(obs_w), 64'(5));
    chk("wr_late_w_rsp_cycles", 64'(obs_rsp), 64'(1));
    chk("wr_late_w_resp", 64'(obs_resp), 64'(2'b01));

    // Read with arready after two cycles.
    run_txn(1'b0, 2, 0, 1, 0, 0, -1, 3'd5, 32'h0, 4'h0, 2'b00, 32'h1234_5678);
    chk("rd_rdata", 64'(obs_rdata), 64'(32'h1234_5678));
    chk("rd_resp", 64'(obs_resp), 64'(2'b00));

    // Read that never sees rvalid: timeout after sixteen wait cycles.
    run_txn(1'b0, 0, 0, 1000, 0, 0, -1, 3'd2, 32'h0, 4'h0, 2'b00, 32'hFFFF_FFFF);
    chk("rd_timeout_latency", 64'(obs_rise - t0), 64'(18));
    chk("rd_timeout_resp", 64'(obs_resp), 64'(2'b10));
    chk("rd_timeout_rdata", 64'(obs_rdata), 64'(0));

    // rvalid on the last wait cycle still wins over the timeout.
    run_txn(1'b0, 0, 0, 15, 0, 0, -1, 3'd1, 32'h0, 4'h0, 2'b11, 32'hCAFE_0001);
    chk("rd_last_chance_latency", 64'(obs_rise - t0), 64'(18));
    chk("rd_last_chance_rdata", 64'(obs_rdata), 64'(32'hCAFE_0001));

    // Write whose bvalid comes one cycle too late.
    run_txn(1'b1, 1, 0, 16, 1, 0, -1, 3'd7, 32'h0F0F_F0F0, 4'h3, 2'b00, 32'h0);
    chk("wr_timeout_resp", 64'(obs_resp), 64'(2'b10));

    // Response held for three cycles before rsp_ready.
    run_txn(1'b1, 0, 0, 0, 3, 0, -1, 3'd4, 32'h1111_2222, 4'hC, 2'b00, 32'h0);
    chk("rsp_hold_cycles", 64'(obs_rsp), 64'(4));

    // Reset while the write address/data phase is still pending.
    run_txn(1'b1, 4, 4, 0, 0, 0, 2, 3'd6, 32'h5555_AAAA, 4'hF, 2'b00, 32'h0);
    chk_en = 1'b0;
    quiet_inputs();
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk_all_zero("abort");
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("abort_ready_after", 64'(bus.cmd_ready), 64'(1));
    @(posedge aclk); #1;
    run_txn(1'b0, 1, 0, 2, 1, 0, -1, 3'd5, 32'h0, 4'h0, 2'b01, 32'h0BAD_F00D);
    chk("post_abort_rdata", 64'(obs_rdata), 64'(32'h0BAD_F00D));
    chk("post_abort_resp", 64'(obs_resp), 64'(2'b01));

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 19), $urandom_range(0, 3), $urandom_range(0, 2), -1,
              AW'($urandom), DW'($urandom), 4'($urandom), 2'($urandom), DW'($urandom));
    end
    chk_en = 1'b0;
    @(negedge aclk);
    chk("final_idle_ready", 64'(bus.cmd_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter addr_width, default 3, AXI address width.
REQ-002 SHALL have parameter data_width, default 32, data width; strobe width is data_width/8.
REQ-003 SHALL have parameter timeout_cycles, default 16, maximum wait cycles for the B/R response.
REQ-004 aclk  input  1  single clock; all logic samples on rising edge.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  addr_width  target address.
REQ-010 cmd_wdata  input  data_width  write data.
REQ-011 cmd_wstrb  input  data_width/8  write byte strobes.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 rsp_rdata  output  data_width  read data (0 for writes).
REQ-015 rsp_resp  output  2  bresp/rresp, or 2'b10 on timeout.
REQ-016 awvalid/awready/awaddr/awprot  out/in/out/out  1/1/addr_width/1  write address channel.
REQ-017 wvalid/wready/wdata/wstrb  out/in/out/out  1/1/data_width/data_width/8  write data channel.
REQ-018 bvalid/bready/bresp  in/out/in  1/1/2  write response channel.
REQ-019 arvalid/arready/araddr/arprot  out/in/out/out  1/1/addr_width/1  read address channel.
REQ-020 rvalid/rready/rdata/rresp  in/out/in/in  1/1/data_width/2  read data channel.

Function
REQ-021 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-022 cmd_ready SHALL be high only in IDLE; on accept, addr/wdata/wstrb/write SHALL be captured; next state WR_REQ if cmd_write, else RD_REQ.
REQ-023 WR_REQ: awvalid and wvalid asserted together from the cycle after accept; each deasserts independently after its own handshake (aw_done/w_done flags); both done -> WR_RESP; the same-cycle handshake on both channels is legal.
REQ-024 awaddr/wdata/wstrb/araddr SHALL hold stable while the corresponding valid is high; awprot = arprot = 0.
REQ-025 WR_RESP: bready high; bvalid&bready -> capture bresp, rsp_rdata=0, go to DONE; bvalid before WR_RESP SHALL be ignored.
REQ-026 RD_REQ: arvalid high until arready; then RD_RESP with rready high; rvalid&rready -> capture rdata/rresp, go to DONE.
REQ-027 Timeout counter SHALL clear on entry to WR_RESP/RD_RESP and increment each waiting cycle; when it reaches timeout_cycles -> rsp_resp=2'b10, rsp_rdata=0, bready/rready low, go to DONE.
REQ-028 DONE: rsp_valid high, outputs stable until rsp_ready; then IDLE; a new command SHALL NOT be accepted in the same cycle.
REQ-029 At most one transaction SHALL be outstanding; minimum latency accept->rsp_valid = 3 cycles with all slave signals ready.

Reset
REQ-030 areset high at a clock edge SHALL force IDLE and all outputs to 0 (cmd_ready goes to 1 the cycle after release), including mid-transaction; the in-flight transaction is abandoned.

Verification
REQ-031 Write addr 3, data 32'hA5A5_0F0F, strb 4'hF, awready=wready=bvalid=1, bresp=0 -> rsp_valid 3 cycles after accept, rsp_resp=0, awaddr=3 and wdata matched during handshake.
REQ-032 Write with wready delayed 4 cycles after awready -> awvalid drops after 1 cycle, wvalid held 5 cycles, single response.
REQ-033 Read addr 5, arready after 2 cycles, rvalid with rdata=32'h1234_5678, rresp=0 -> rsp_rdata=32'h1234_5678, rsp_resp=0.
REQ-034 Read with rvalid never asserted -> rsp_valid after timeout_cycles (16) wait cycles with rsp_resp=2'b10, rready low afterwards.
REQ-035 areset asserted during WR_REQ -> next cycle all outputs 0, then IDLE; following read completes normally.
REQ-036 rsp_ready held low 3 cycles in DONE -> rsp_* stable, cmd_ready low until release.
